// File: rtl/wksg_pkg.sv
// Shared constants, FSM state type and sizing helper for the wksg round-robin arbiter.
package wksg_pkg;

  localparam int unsigned WKSG_CODE_REL = 0;
  localparam int unsigned WKSG_CODE_REQ = 1;

  typedef enum logic [0:0] {
    WKSG_IDLE,
    WKSG_BUSY
  } wksg_state_e;

  // Ceil-log2 with a floor of 1 so index vectors never collapse to zero width.
  function automatic int unsigned wksg_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/wksg_rr_arb_if.sv
// Channel-command / grant bundle between channel controllers (master) and the arbiter (slave).
interface wksg_rr_arb_if
  import wksg_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CODE_W = 2
) ();

  localparam int unsigned IDX_W = wksg_clog2(NUM_CH);

  logic [NUM_CH*CODE_W-1:0] code;
  logic [NUM_CH-1:0]        req_flag;
  logic [NUM_CH-1:0]        grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;
  logic                     timeout_pulse;

  modport master (
    output code,
    input  req_flag, grant, grant_idx, grant_valid, timeout_pulse
  );

  modport slave (
    input  code,
    output req_flag, grant, grant_idx, grant_valid, timeout_pulse
  );

endinterface

// File: rtl/wksg_rr_pick.sv
// Combinational round-robin picker: first set flag at or above ptr, wrapping to channel 0.
module wksg_rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] flags,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  pick,
  output logic              any_valid
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walking offsets from ptr is the rotate / priority-encode / unrotate chain in one loop.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NUM_CH);
      if (!found && flags[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign any_valid = |flags;

endmodule

// File: rtl/wksg_rr_arb.sv
// Round-robin lock-until-release arbiter over NUM_CH command-coded channels.
// Optional forced rotation after MAX_HOLD owner cycles when WKSG_TIMEOUT_EN is defined.
module wksg_rr_arb
  import wksg_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CODE_W   = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst,
  wksg_rr_arb_if.slave bus
);

  localparam int unsigned IDX_W = wksg_clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || CODE_W < 2 || MAX_HOLD < 2) begin : g_bad_param
    $error("wksg_rr_arb: illegal parameter set");
  end

  wksg_state_e       state_q, state_d;
  logic [NUM_CH-1:0] flag_q, flag_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  pick;
  logic              pick_any;
  logic              take;

`ifdef WKSG_TIMEOUT_EN
  localparam int unsigned HoldW = wksg_clog2(MAX_HOLD);
  logic [HoldW-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  always_comb begin
    flag_d = flag_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.code[i*CODE_W +: CODE_W] == CODE_W'(WKSG_CODE_REL)) begin
        flag_d[i] = 1'b0;
      end else if (bus.code[i*CODE_W +: CODE_W] == CODE_W'(WKSG_CODE_REQ)) begin
        flag_d[i] = 1'b1;
      end
    end
  end

  // Masking the owner lets the same picker serve idle, release handoff and forced rotation.
  wksg_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .flags     (flag_q & ~grant_q),
    .ptr       (ptr_q),
    .pick      (pick),
    .any_valid (pick_any)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
`ifdef WKSG_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      WKSG_IDLE: begin
        if (pick_any) take = 1'b1;
      end
      WKSG_BUSY: begin
        if (flag_q[idx_q]) begin
`ifdef WKSG_TIMEOUT_EN
          if (cnt_q == HoldW'(MAX_HOLD - 1)) begin
            if (pick_any) begin
              take = 1'b1;
              to_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end else if (pick_any) begin
          take = 1'b1;
        end else begin
          state_d = WKSG_IDLE;
          idx_d   = '0;
`ifdef WKSG_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
    endcase
    if (take) begin
      state_d = WKSG_BUSY;
      idx_d   = pick;
      ptr_d   = (pick == IDX_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
`ifdef WKSG_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
    grant_d = (state_d == WKSG_BUSY) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WKSG_IDLE;
      flag_q  <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef WKSG_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef WKSG_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.req_flag    = flag_q;
  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = (state_q == WKSG_BUSY);
`ifdef WKSG_TIMEOUT_EN
  assign bus.timeout_pulse = to_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wksg_rr_arb.sv
// Directed self-checking bench for wksg_rr_arb (NUM_CH=4, CODE_W=2, MAX_HOLD=4).
module tb_wksg_rr_arb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  wksg_rr_arb_if #(.NUM_CH(4), .CODE_W(2)) bus ();

  wksg_rr_arb #(
    .NUM_CH   (4),
    .CODE_W   (2),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_code(input int ch, input logic [1:0] v);
    bus.code[ch*2 +: 2] = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.code = '0;
    step(2);
    rst = 1'b0;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.req_flag !== 4'b0000) begin errors++; $display("FAIL reset_flag got=%b exp=0000", bus.req_flag); end
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.grant_valid); end
    checks++; if (bus.grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus.grant_idx); end
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", bus.timeout_pulse); end
  endtask

  task automatic test_basic();
    set_code(1, 2'd1);
    step(1);
    checks++; if (bus.req_flag !== 4'b0010) begin errors++; $display("FAIL basic_flag got=%b exp=0010", bus.req_flag); end
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL basic_lat got=%b exp=0000", bus.grant); end
    step(1);
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL basic_grant got=%b exp=0010", bus.grant); end
    checks++; if (bus.grant_idx !== 2'd1) begin errors++; $display("FAIL basic_idx got=%0d exp=1", bus.grant_idx); end
    checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.grant_valid); end
    set_code(1, 2'd3);
    step(3);
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL basic_hold got=%b exp=0010", bus.grant); end
    checks++; if (bus.req_flag !== 4'b0010) begin errors++; $display("FAIL basic_hold_flag got=%b exp=0010", bus.req_flag); end
  endtask

  task automatic test_release_idle();
    set_code(1, 2'd0);
    step(1);
    checks++; if (bus.req_flag !== 4'b0000) begin errors++; $display("FAIL rel_flag got=%b exp=0000", bus.req_flag); end
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL rel_lat got=%b exp=0010", bus.grant); end
    step(1);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rel_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rel_valid got=%b exp=0", bus.grant_valid); end
    checks++; if (bus.grant_idx !== 2'd0) begin errors++; $display("FAIL rel_idx got=%0d exp=0", bus.grant_idx); end
  endtask

  task automatic test_handoff();
    set_code(2, 2'd1);
    step(2);
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL ho_own2 got=%b exp=0100", bus.grant); end
    set_code(0, 2'd1);
    set_code(3, 2'd1);
    set_code(2, 2'd3);
    step(1);
    checks++; if (bus.req_flag !== 4'b1101) begin errors++; $display("FAIL ho_flags got=%b exp=1101", bus.req_flag); end
    set_code(2, 2'd0);
    step(1);
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL ho_still2 got=%b exp=0100", bus.grant); end
    step(1);
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL ho_to3 got=%b exp=1000", bus.grant); end
    checks++; if (bus.grant_idx !== 2'd3) begin errors++; $display("FAIL ho_idx3 got=%0d exp=3", bus.grant_idx); end
    set_code(3, 2'd0);
    step(1);
    checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL ho_nobubble got=%b exp=1", bus.grant_valid); end
    step(1);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL ho_wrap0 got=%b exp=0001", bus.grant); end
    set_code(0, 2'd0);
    step(2);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL ho_idle got=%b exp=0000", bus.grant); end
  endtask

  task automatic test_reset_mid();
    set_code(2, 2'd1);
    step(2);
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL rm_pre got=%b exp=0100", bus.grant); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rm_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.req_flag !== 4'b0000) begin errors++; $display("FAIL rm_flag got=%b exp=0000", bus.req_flag); end
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", bus.grant_valid); end
    set_code(2, 2'd0);
    set_code(0, 2'd1);
    rst = 1'b0;
    step(1);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rm_lat got=%b exp=0000", bus.grant); end
    step(1);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL rm_post got=%b exp=0001", bus.grant); end
    set_code(0, 2'd0);
    step(2);
  endtask

  task automatic test_timeout();
    int bad_grant;
    int pulses;
    set_code(0, 2'd1);
    step(2);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL to_own0 got=%b exp=0001", bus.grant); end
    set_code(1, 2'd1);
`ifdef WKSG_TIMEOUT_EN
    step(3);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL to_hold got=%b exp=0001", bus.grant); end
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", bus.timeout_pulse); end
    step(1);
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL to_rot got=%b exp=0010", bus.grant); end
    checks++; if (bus.timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", bus.timeout_pulse); end
    checks++; if (bus.req_flag !== 4'b0011) begin errors++; $display("FAIL to_flags got=%b exp=0011", bus.req_flag); end
    step(1);
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_end got=%b exp=0", bus.timeout_pulse); end
`else
    bad_grant = 0;
    pulses    = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.grant !== 4'b0001) bad_grant++;
      if (bus.timeout_pulse !== 1'b0) pulses++;
    end
    checks++; if (bad_grant != 0) begin errors++; $display("FAIL to_nohold got=%0d exp=0 lost-grant cycles", bad_grant); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL to_nopulse got=%0d exp=0 pulses", pulses); end
`endif
    set_code(0, 2'd0);
    set_code(1, 2'd0);
    step(3);
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL to_idle got=%b exp=0", bus.grant_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_release_idle();
    test_handoff();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
